spi_ringbuf_bridge: RTL and testbench

Byte-wide capture ring buffer exposed on the SPI slave's BRAM-style bus (rd, wr, addr, data). It sits directly downstream of the SPI RW slave and supplies that slave's `data_in`. A sample stream (GPS/sensor bytes) fills the ring. The ESP32 master reads buffered bytes and pointers over SPI and frees space by writing the read pointer.

---
 rtl/spi_ringbuf_bridge.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_ringbuf_bridge.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_ringbuf_bridge.sv
// Byte capture ring buffer behind the SPI slave's rd/wr/addr/data bus.
// Optional RINGBUF_PTR_SNAPSHOT_EN: reading offset 0 freezes the wptr/count high bytes for offsets 1 and 7.
module spi_ringbuf_bridge #(
   parameter int c_addr_bits = 16,
   parameter int c_buf_bits  = 10
)(
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   sample_valid,
   input  logic [7:0]             sample_data,
   input  logic                   rd,
   input  logic                   wr,
   input  logic [c_addr_bits-1:0] addr,
   input  logic [7:0]             bus_wdata,
   output logic [7:0]             bus_rdata,
   output logic                   irq_nonempty
);

   localparam int c_depth = 1 << c_buf_bits;

   logic [7:0]            r_mem [0:c_depth-1];
   logic [7:0]            r_mem_rdata;

   logic                  r_rd_q;
   logic                  r_wr_q;
   logic [c_buf_bits-1:0] r_wptr;
   logic [c_buf_bits-1:0] r_rptr;
   logic [7:0]            r_rptr_stage;
   logic                  r_enable;
   logic                  r_overflow;
   logic                  r_irq;
   logic                  r_rd_pend;
   logic                  r_rd_sel_reg;
   logic [7:0]            r_reg_rdata;
   logic [7:0]            r_bus_rdata;

   logic                  w_rd_stb;
   logic                  w_wr_stb;
   logic                  w_reg_sel;
   logic                  w_off_ok;
   logic [2:0]            w_off;
   logic [c_buf_bits-1:0] w_buf_idx;
   logic                  w_reg_wr;
   logic                  w_stage_en;
   logic                  w_commit_en;
   logic                  w_ctrl_wr;
   logic                  w_stat_wr;
   logic                  w_clear;
   logic [c_buf_bits-1:0] w_wptr_inc;
   logic [c_buf_bits-1:0] w_count;
   logic [c_buf_bits-1:0] w_rptr_commit;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_cap_req;
   logic                  w_capture;
   logic                  w_drop;
   logic                  w_snap_load;
   logic [15:0]           w_wptr_ext;
   logic [15:0]           w_rptr_ext;
   logic [15:0]           w_count_ext;
   logic [7:0]            w_wptr_hi_rd;
   logic [7:0]            w_count_hi_rd;
   logic [7:0]            w_reg_rdata;

   // Level-to-pulse: a held rd/wr produces exactly one access.
   assign w_rd_stb  = rd & ~r_rd_q;
   assign w_wr_stb  = wr & ~r_wr_q;

   assign w_reg_sel = addr[c_addr_bits-1];
   assign w_off_ok  = (addr[c_addr_bits-2:3] == '0);
   assign w_off     = addr[2:0];
   assign w_buf_idx = addr[c_buf_bits-1:0];

   assign w_reg_wr    = w_wr_stb & w_reg_sel & w_off_ok;
   assign w_stage_en  = w_reg_wr & (w_off == 3'd2);
   assign w_commit_en = w_reg_wr & (w_off == 3'd3);
   assign w_ctrl_wr   = w_reg_wr & (w_off == 3'd4);
   assign w_stat_wr   = w_reg_wr & (w_off == 3'd5);
   assign w_clear     = w_ctrl_wr & bus_wdata[1];
   assign w_snap_load = w_rd_stb & w_reg_sel & w_off_ok & (w_off == 3'd0);

   assign w_wptr_inc = r_wptr + c_buf_bits'(1);
   assign w_count    = r_wptr - r_rptr;
   assign w_full     = (w_wptr_inc == r_rptr);
   assign w_empty    = (r_wptr == r_rptr);

   // Clear wins over a same-cycle sample: it is neither stored nor counted as overflow.
   assign w_cap_req  = sample_valid & r_enable;
   assign w_capture  = w_cap_req & ~w_full & ~w_clear;
   assign w_drop     = w_cap_req & w_full & ~w_clear;

   generate
      if (c_buf_bits > 8) begin : g_wide_ptr
         assign w_rptr_commit = {bus_wdata[c_buf_bits-9:0], r_rptr_stage};
      end else begin : g_narrow_ptr
         assign w_rptr_commit = r_rptr_stage[c_buf_bits-1:0];
      end
   endgenerate

   always_comb begin
      w_wptr_ext                   = '0;
      w_rptr_ext                   = '0;
      w_count_ext                  = '0;
      w_wptr_ext[c_buf_bits-1:0]   = r_wptr;
      w_rptr_ext[c_buf_bits-1:0]   = r_rptr;
      w_count_ext[c_buf_bits-1:0]  = w_count;
   end

`ifdef RINGBUF_PTR_SNAPSHOT_EN
   logic [7:0] r_snap_wptr_hi;
   logic [7:0] r_snap_count_hi;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_snap_wptr_hi  <= 8'h00;
         r_snap_count_hi <= 8'h00;
      end else if (w_snap_load) begin
         r_snap_wptr_hi  <= w_wptr_ext[15:8];
         r_snap_count_hi <= w_count_ext[15:8];
      end
   end

   assign w_wptr_hi_rd  = r_snap_wptr_hi;
   assign w_count_hi_rd = r_snap_count_hi;
`else
   logic w_snap_unused;
   assign w_snap_unused = w_snap_load;
   assign w_wptr_hi_rd  = w_wptr_ext[15:8];
   assign w_count_hi_rd = w_count_ext[15:8];
`endif

   always_comb begin
      w_reg_rdata = 8'h00;
      if (w_off_ok) begin
         case (w_off)
            3'd0:    w_reg_rdata = w_wptr_ext[7:0];
            3'd1:    w_reg_rdata = w_wptr_hi_rd;
            3'd2:    w_reg_rdata = w_rptr_ext[7:0];
            3'd3:    w_reg_rdata = w_rptr_ext[15:8];
            3'd4:    w_reg_rdata = {7'b0, r_enable};
            3'd5:    w_reg_rdata = {5'b0, w_empty, w_full, r_overflow};
            3'd6:    w_reg_rdata = w_count_ext[7:0];
            default: w_reg_rdata = w_count_hi_rd;
         endcase
      end
   end

   // Unreset array and read register so the buffer maps onto block RAM; old data on read-during-write.
   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_mem[r_wptr] <= sample_data;
      end
      if (w_rd_stb) begin
         r_mem_rdata <= r_mem[w_buf_idx];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rd_q       <= 1'b0;
         r_wr_q       <= 1'b0;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_rptr_stage <= 8'h00;
         r_enable     <= 1'b0;
         r_overflow   <= 1'b0;
         r_irq        <= 1'b0;
      end else begin
         r_rd_q <= rd;
         r_wr_q <= wr;
         if (w_clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_capture) begin
               r_wptr <= w_wptr_inc;
            end
            if (w_commit_en) begin
               r_rptr <= w_rptr_commit;
            end
         end
         if (w_stage_en) begin
            r_rptr_stage <= bus_wdata;
         end
         if (w_ctrl_wr) begin
            r_enable <= bus_wdata[0];
         end
         // A drop in the same cycle as a W1C leaves overflow set.
         if (w_clear) begin
            r_overflow <= 1'b0;
         end else if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (w_stat_wr & bus_wdata[0]) begin
            r_overflow <= 1'b0;
         end
         r_irq <= (w_count != '0);
      end
   end

   // Read pipeline: sources captured on the strobe, output register loaded one cycle later.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rd_pend    <= 1'b0;
         r_rd_sel_reg <= 1'b0;
         r_reg_rdata  <= 8'h00;
         r_bus_rdata  <= 8'h00;
      end else begin
         r_rd_pend <= w_rd_stb;
         if (w_rd_stb) begin
            r_rd_sel_reg <= w_reg_sel;
            r_reg_rdata  <= w_reg_rdata;
         end
         if (r_rd_pend) begin
            r_bus_rdata <= r_rd_sel_reg ? r_reg_rdata : r_mem_rdata;
         end
      end
   end

   assign bus_rdata    = r_bus_rdata;
   assign irq_nonempty = r_irq;

endmodule

// File: tb/tb_spi_ringbuf_bridge.sv
// Directed bench for spi_ringbuf_bridge at default parameters (depth 1024).
module tb_spi_ringbuf_bridge;

   logic        clk = 1'b0;
   logic        rstn;
   logic        sample_valid;
   logic [7:0]  sample_data;
   logic        rd;
   logic        wr;
   logic [15:0] addr;
   logic [7:0]  bus_wdata;
   logic [7:0]  bus_rdata;
   logic        irq_nonempty;

   int n_cmp = 0;
   int n_mis = 0;
   logic [7:0] d;

`ifdef RINGBUF_PTR_SNAPSHOT_EN
   localparam logic [7:0] c_hi_after_cross = 8'h00;
`else
   localparam logic [7:0] c_hi_after_cross = 8'h01;
`endif

   always #5 clk = ~clk;

   spi_ringbuf_bridge #(.c_addr_bits(16), .c_buf_bits(10)) u_dut (
      .clk          (clk),
      .rstn         (rstn),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .rd           (rd),
      .wr           (wr),
      .addr         (addr),
      .bus_wdata    (bus_wdata),
      .bus_rdata    (bus_rdata),
      .irq_nonempty (irq_nonempty)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
      end
      $display("check %-14s observed 0x%02h expected 0x%02h", tag, obs, exp);
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [7:0] q);
      @(posedge clk); #1;
      addr = a;
      rd   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      q  = bus_rdata;
      rd = 1'b0;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] v);
      @(posedge clk); #1;
      addr      = a;
      bus_wdata = v;
      wr        = 1'b1;
      @(posedge clk); #1;
      wr = 1'b0;
   endtask

   task automatic push_seq(input int n, input logic [7:0] first, input int step);
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         sample_valid = 1'b1;
         sample_data  = 8'(int'(first) + i * step);
         @(posedge clk); #1;
      end
      sample_valid = 1'b0;
   endtask

   task automatic reg_chk(input string tag, input logic [2:0] off, input logic [7:0] exp);
      logic [7:0] q;
      bus_read(16'h8000 | 16'(off), q);
      chk(tag, q, exp);
   endtask

   task automatic buf_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
      logic [7:0] q;
      bus_read(a, q);
      chk(tag, q, exp);
   endtask

   initial begin
      rstn = 1'b0; sample_valid = 1'b0; sample_data = 8'h00;
      rd = 1'b0; wr = 1'b0; addr = 16'h0000; bus_wdata = 8'h00;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      chk("rst_rdata", bus_rdata, 8'h00);
      chk("rst_irq", {7'b0, irq_nonempty}, 8'h00);
      for (int k = 0; k < 8; k++) begin
         reg_chk($sformatf("rst_off%0d", k), 3'(k), (k == 5) ? 8'h04 : 8'h00);
      end

      // Enable and push three bytes; irq lags the first capture by two cycles.
      bus_write(16'h8004, 8'h01);
      @(posedge clk); #1;
      sample_valid = 1'b1; sample_data = 8'h11;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      chk("irq_p1", {7'b0, irq_nonempty}, 8'h00);
      @(posedge clk); #1;
      chk("irq_p2", {7'b0, irq_nonempty}, 8'h01);
      push_seq(2, 8'h22, 8'h11);
      @(posedge clk); #1;
      chk("irq_3", {7'b0, irq_nonempty}, 8'h01);
      reg_chk("wptr_lo_3", 3'd0, 8'h03);
      reg_chk("count_lo_3", 3'd6, 8'h03);
      reg_chk("count_hi_3", 3'd7, 8'h00);
      buf_chk("buf0", 16'h0000, 8'h11);
      buf_chk("buf1", 16'h0001, 8'h22);
      buf_chk("buf2", 16'h0002, 8'h33);

      // Fill to full with rptr=0: 1020 captures then drops.
      push_seq(1030, 8'h40, 1);
      reg_chk("full_wlo", 3'd0, 8'hFF);
      reg_chk("full_whi", 3'd1, 8'h03);
      reg_chk("full_stat", 3'd5, 8'h03);
      reg_chk("full_clo", 3'd6, 8'hFF);
      reg_chk("full_chi", 3'd7, 8'h03);
      buf_chk("buf3", 16'h0003, 8'h40);
      buf_chk("buf1022", 16'h03FE, 8'h3B);
      bus_write(16'h8005, 8'h01);
      reg_chk("w1c_stat", 3'd5, 8'h02);
      bus_write(16'h8002, 8'hFF);
      reg_chk("stage_stat", 3'd5, 8'h02);
      reg_chk("stage_rlo", 3'd2, 8'h00);
      bus_write(16'h8003, 8'h03);
      reg_chk("cmt_stat", 3'd5, 8'h04);
      reg_chk("cmt_rlo", 3'd2, 8'hFF);
      reg_chk("cmt_rhi", 3'd3, 8'h03);
      reg_chk("cmt_count", 3'd6, 8'h00);

      // Wrap from index 1023 through 0.
      push_seq(4, 8'hA1, 1);
      reg_chk("wrap_wlo", 3'd0, 8'h03);
      reg_chk("wrap_whi", 3'd1, 8'h00);
      reg_chk("wrap_count", 3'd6, 8'h04);
      buf_chk("wrap_buf1", 16'h0001, 8'hA3);
      buf_chk("wrap_buf3ff", 16'h03FF, 8'hA1);
      buf_chk("wrap_mod", 16'h0401, 8'hA3);

      // Make it full (rptr = wptr+1), then drop a sample.
      bus_write(16'h8002, 8'h04);
      bus_write(16'h8003, 8'h00);
      reg_chk("ovf_pre", 3'd5, 8'h02);
      push_seq(1, 8'h5A, 0);
      reg_chk("ovf_set", 3'd5, 8'h03);
      reg_chk("ovf_wptr", 3'd0, 8'h03);
      // W1C and drop together: overflow stays set.
      @(posedge clk); #1;
      addr = 16'h8005; bus_wdata = 8'h01; wr = 1'b1;
      sample_valid = 1'b1; sample_data = 8'h5B;
      @(posedge clk); #1;
      wr = 1'b0; sample_valid = 1'b0;
      reg_chk("ovf_w1c_drop", 3'd5, 8'h03);

      // Clear together with a sample: sample not stored, overflow cleared.
      @(posedge clk); #1;
      addr = 16'h8004; bus_wdata = 8'h03; wr = 1'b1;
      sample_valid = 1'b1; sample_data = 8'hEE;
      @(posedge clk); #1;
      wr = 1'b0; sample_valid = 1'b0;
      reg_chk("clr_stat", 3'd5, 8'h04);
      reg_chk("clr_wptr", 3'd0, 8'h00);
      reg_chk("clr_rptr", 3'd2, 8'h00);
      buf_chk("clr_buf0", 16'h0000, 8'hA2);
      chk("clr_irq", {7'b0, irq_nonempty}, 8'h00);
      reg_chk("clr_ctrl", 3'd4, 8'h01);

      // rd held ~20 cycles with the address changing after the strobe.
      @(posedge clk); #1;
      addr = 16'h0001; rd = 1'b1;
      @(posedge clk); #1;
      chk("hold_n1", bus_rdata, 8'h01);
      addr = 16'h0002;
      @(posedge clk); #1;
      chk("hold_n2", bus_rdata, 8'hA3);
      repeat (18) @(posedge clk);
      #1;
      chk("hold_n20", bus_rdata, 8'hA3);
      rd = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("hold_after", bus_rdata, 8'hA3);

      // wptr crossing 0x0FF -> 0x100 between low and high reads.
      push_seq(255, 8'h00, 1);
      reg_chk("x_wlo", 3'd0, 8'hFF);
      bus_write(16'h800C, 8'h00);
      push_seq(1, 8'hC0, 0);
      reg_chk("x_whi", 3'd1, c_hi_after_cross);
      reg_chk("x_chi", 3'd7, c_hi_after_cross);
      reg_chk("x_clo", 3'd6, 8'h00);
      reg_chk("x2_wlo", 3'd0, 8'h00);
      reg_chk("x2_whi", 3'd1, 8'h01);
      reg_chk("x2_chi", 3'd7, 8'h01);
      buf_chk("x_buf100", 16'h00FF, 8'hC0);
      bus_read(16'h8008, d);
      chk("bad_off", d, 8'h00);

      // Disabled capture ignores samples.
      bus_write(16'h8004, 8'h00);
      push_seq(3, 8'h77, 1);
      reg_chk("dis_wlo", 3'd0, 8'h00);
      reg_chk("dis_whi", 3'd1, 8'h01);
      reg_chk("dis_ctrl", 3'd4, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
